regfile_sequencer: RTL and testbench

Multi-cycle instruction sequencer that sits directly upstream of the 16×8 register file. It fetches 16-bit instructions from an external combinational ROM and drives the register file read addresses. It captures the returned operands, computes an 8-bit result, and issues the write-back (write enable, address, data) to the register file. Datapath width matches the register file: 8-bit data, 4-bit register addresses, register 0 reads as zero.

---
 rtl/seq_pkg.sv | 53 +++++
 rtl/seq_alu.sv | 40 ++++
 rtl/regfile_sequencer.sv | 159 +++++++++++++++
 tb/tb_regfile_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, field positions and defaults for regfile_sequencer
package seq_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_AW  = 4;
    localparam int DEF_PCW = 8;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_MOV  = 4'h7,
        OP_JMP  = 4'h8,
        OP_BZ   = 4'h9,
        OP_BC   = 4'hA,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_e;

    // Arithmetic/logic ops: the only ones that touch the flags.
    function automatic logic is_alu_op(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    // Ops that produce a register write-back result.
    function automatic logic is_write_op(input op_e op);
        return is_alu_op(op) || (op == OP_LDI) || (op == OP_MOV);
    endfunction

endpackage

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - combinational result unit; carry output only with SEQ_FLAGS_EN
module seq_alu
    import seq_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  op_e           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
`ifdef SEQ_FLAGS_EN
    output logic          carry,
`endif
    output logic [DW-1:0] result
);

    // Result select; SUB carry is the borrow bit of the extended subtraction.
    always_comb begin
        result = '0;
`ifdef SEQ_FLAGS_EN
        carry  = 1'b0;
`endif
        case (op)
`ifdef SEQ_FLAGS_EN
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
`else
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
`endif
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LDI:  result = imm;
            OP_MOV:  result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - multi-cycle sequencer driving a 16x8 register file; optional SEQ_FLAGS_EN
module regfile_sequencer
    import seq_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int PCW = DEF_PCW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [PCW-1:0] pc,
    input  logic [15:0]    instr,
    output logic [AW-1:0]  ra1,
    output logic [AW-1:0]  ra2,
    input  logic [DW-1:0]  rd1,
    input  logic [DW-1:0]  rd2,
    output logic           we3,
    output logic [AW-1:0]  wa3,
    output logic [DW-1:0]  wd3,
`ifdef SEQ_FLAGS_EN
    output logic           flag_z,
    output logic           flag_c,
`endif
    output logic           busy,
    output logic           halted
);

    state_e         state_q, state_d;
    logic [15:0]    ir_q;
    logic [PCW-1:0] pc_q, pc_next;
    logic [DW-1:0]  a_q, b_q, r_q;
    logic           we3_q;
    logic [AW-1:0]  wa3_q;
    logic           halted_q;
    logic [DW-1:0]  alu_result;
`ifdef SEQ_FLAGS_EN
    logic           alu_carry;
    logic           z_q, c_q;
`endif

    op_e            op;
    logic [3:0]     rd_f, rs1_f, rs2_f;
    logic [7:0]     imm_f;

    assign op    = op_e'(ir_q[OP_MSB:OP_LSB]);
    assign rd_f  = ir_q[RD_MSB:RD_LSB];
    assign rs1_f = ir_q[RS1_MSB:RS1_LSB];
    assign rs2_f = ir_q[RS2_MSB:RS2_LSB];
    assign imm_f = ir_q[IMM_MSB:IMM_LSB];

    assign pc     = pc_q;
    assign ra1    = rs1_f;
    assign ra2    = rs2_f;
    assign we3    = we3_q;
    assign wa3    = wa3_q;
    assign wd3    = r_q;
    assign busy   = (state_q != S_IDLE);
    assign halted = halted_q;
`ifdef SEQ_FLAGS_EN
    assign flag_z = z_q;
    assign flag_c = c_q;
`endif

    seq_alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (a_q),
        .b      (b_q),
        .imm    (DW'(imm_f)),
`ifdef SEQ_FLAGS_EN
        .carry  (alu_carry),
`endif
        .result (alu_result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: fixed FETCH/DECODE/EXEC/WB walk, HALT bails out of EXEC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (op == OP_HALT) ? S_IDLE : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next pc chosen in WB; branch conditions read the captured operand/flag.
    always_comb begin
        pc_next = pc_q + PCW'(1);
        case (op)
            OP_JMP: pc_next = PCW'(imm_f);
            OP_BZ:  if (a_q == '0) pc_next = PCW'({rd_f, rs2_f});
`ifdef SEQ_FLAGS_EN
            OP_BC:  if (c_q) pc_next = PCW'({rd_f, rs2_f});
`endif
            default: pc_next = pc_q + PCW'(1);
        endcase
    end

    // Datapath registers, each loaded in its owning state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= '0;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            halted_q <= 1'b0;
`ifdef SEQ_FLAGS_EN
            z_q      <= 1'b0;
            c_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) halted_q <= 1'b0;
                end
                S_FETCH: begin
                    ir_q <= instr;
                end
                S_DECODE: begin
                    a_q <= rd1;
                    b_q <= rd2;
                end
                S_EXEC: begin
                    if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                    end else begin
                        r_q   <= alu_result;
                        wa3_q <= AW'(rd_f);
                        we3_q <= is_write_op(op) && (rd_f != 4'h0);
`ifdef SEQ_FLAGS_EN
                        if (is_alu_op(op)) begin
                            z_q <= (alu_result == '0);
                            c_q <= alu_carry;
                        end
`endif
                    end
                end
                S_WB: begin
                    we3_q <= 1'b0;
                    pc_q  <= pc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - directed self-checking bench for regfile_sequencer
module tb_regfile_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [3:0]  ra1, ra2;
    logic [7:0]  rd1, rd2;
    logic        we3;
    logic [3:0]  wa3;
    logic [7:0]  wd3;
    logic        busy;
    logic        halted;
`ifdef SEQ_FLAGS_EN
    logic        flag_z, flag_c;
`endif

    logic [15:0] rom [256];
    logic [7:0]  regs [16];
    logic        rf_clear;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .pc     (pc),
        .instr  (instr),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .we3    (we3),
        .wa3    (wa3),
        .wd3    (wd3),
`ifdef SEQ_FLAGS_EN
        .flag_z (flag_z),
        .flag_c (flag_c),
`endif
        .busy   (busy),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr = rom[pc];
    assign rd1   = (ra1 == 4'h0) ? 8'h00 : regs[ra1];
    assign rd2   = (ra2 == 4'h0) ? 8'h00 : regs[ra2];

    // Register file model: commits on the edge that ends WB.
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else if (we3 && wa3 != 4'h0) begin
            regs[wa3] <= wd3;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        rf_clear = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        step();
        step();
        rst_n    = 1'b1;
        rf_clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_add_prog();
        rom[0] = 16'h6105;
        rom[1] = 16'h6203;
        rom[2] = 16'h1312;
        rom[3] = 16'hF000;
    endtask

    initial begin
        logic we_seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        rf_clear = 1'b1;

        // Reset state
        do_reset();
        check("rst_pc", pc, 0);
        check("rst_we3", we3, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_ra1", ra1, 0);
        check("rst_ra2", ra2, 0);
        check("rst_wa3", wa3, 0);
        check("rst_wd3", wd3, 0);

        // LDI/LDI/ADD/HALT: writes in cycles 4, 8, 12
        load_add_prog();
        pulse_start();
        check("t1_busy", busy, 1);
        for (int k = 0; k < 15; k++) begin
            check($sformatf("t1_we3_c%0d", k + 1), we3, (k == 3 || k == 7 || k == 11) ? 1 : 0);
            if (k == 3) begin
                check("t1_wa3_c4", wa3, 1);
                check("t1_wd3_c4", wd3, 8'h05);
            end
            if (k == 7) begin
                check("t1_wa3_c8", wa3, 2);
                check("t1_wd3_c8", wd3, 8'h03);
            end
            if (k == 11) begin
                check("t1_wa3_c12", wa3, 3);
                check("t1_wd3_c12", wd3, 8'h08);
            end
            step();
        end
        check("t1_halted", halted, 1);
        check("t1_busy_end", busy, 0);
        check("t1_pc", pc, 3);
        check("t1_r3", regs[3], 8'h08);

        // LDI r0 never writes
        do_reset();
        rom[0] = 16'h60FF;
        rom[1] = 16'hF000;
        pulse_start();
        we_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (we3) we_seen = 1'b1;
            step();
        end
        check("t2_we3_r0", we_seen, 0);
        check("t2_halted", halted, 1);

        // LDI 0, SUB to zero, BZ taken to 0x40
        do_reset();
        rom[0]    = 16'h6100;
        rom[1]    = 16'h2211;
        rom[2]    = 16'h9410;
        rom[8'h40] = 16'hF000;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            if (k == 7) begin
                check("t3_sub_we3", we3, 1);
                check("t3_sub_wa3", wa3, 2);
                check("t3_sub_wd3", wd3, 8'h00);
            end
            if (k == 8)  check("t3_pc_bz", pc, 2);
            if (k == 11) check("t3_bz_we3", we3, 0);
            if (k == 12) check("t3_pc_target", pc, 8'h40);
            step();
        end
        check("t3_halted", halted, 1);
        check("t3_pc_end", pc, 8'h40);

        // pc wraps 0xFF -> 0x00 through a NOP
        do_reset();
        rom[0]     = 16'h80FF;
        rom[8'hFF] = 16'h0000;
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            if (k == 3) check("t4_jmp_we3", we3, 0);
            if (k == 4) check("t4_pc_ff", pc, 8'hFF);
            if (k == 7) check("t4_nop_we3", we3, 0);
            if (k == 8) check("t4_pc_wrap", pc, 8'h00);
            step();
        end

        // Reset during WB of ADD r3 drops we3 immediately, no commit
        do_reset();
        load_add_prog();
        pulse_start();
        for (int k = 0; k < 11; k++) step();
        check("t5_we3_wb", we3, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_we3_async", we3, 0);
        check("t5_pc_async", pc, 0);
        check("t5_busy_async", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("t5_busy_idle", busy, 0);
        check("t5_pc_idle", pc, 0);
        check("t5_r3_nowrite", regs[3], 8'h00);

`ifdef SEQ_FLAGS_EN
        // Carry/zero from 0xFF+0x01 then BC taken to 0x20
        do_reset();
        rom[0]     = 16'h61FF;
        rom[1]     = 16'h6201;
        rom[2]     = 16'h1312;
        rom[3]     = 16'hA200;
        rom[8'h20] = 16'hF000;
        pulse_start();
        for (int k = 0; k < 17; k++) begin
            if (k == 11) begin
                check("t6_wd3", wd3, 8'h00);
                check("t6_flag_z", flag_z, 1);
                check("t6_flag_c", flag_c, 1);
            end
            if (k == 16) check("t6_pc_bc", pc, 8'h20);
            step();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
